pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/load_use_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/trap controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSN             = 32'h0000_0013;
  localparam int          DRAIN_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/load_use_detect.sv
// Flags a decode-stage read of a register still being loaded by the EX stage.
module load_use_detect (
  input  logic [4:0] i_id_rs1_addr,
  input  logic [4:0] i_id_rs2_addr,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_rd_addr,
  input  logic       i_ex_is_load,
  output logic       o_hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign rs1_hit  = i_id_use_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
  assign rs2_hit  = i_id_use_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
  assign o_hazard = i_ex_is_load && (i_ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/redirect control for a 3-stage front end, with interrupt drain and trap entry.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_use_rs1,
  input  logic        i_id_use_rs2,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_is_load,
  input  logic        i_ex_mispredict,
  input  logic [31:0] i_ex_target_pc,
  input  logic        i_ex_mret,
  input  logic [31:0] i_mepc,
  input  logic        i_irq_pending,
  input  logic [3:0]  i_irq_cause,
  input  logic        i_mie,
  input  logic [31:0] i_mtvec,
  input  logic        i_id_insn_vld,
  input  logic [31:0] i_id_pc,
  input  logic [31:0] i_if_pc,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_id_ex_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_trap_take,
  output logic [31:0] o_trap_epc,
  output logic [3:0]  o_trap_cause,
  output logic        o_busy
);

  localparam logic [1:0] CNT_INIT = 2'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic [31:0] epc_q,   epc_d;
  logic [3:0]  cause_q, cause_d;

  logic        hazard;
  logic        redir_act;
  logic [31:0] redir_pc;
  logic        irq_take;

  load_use_detect u_load_use_detect (
    .i_id_rs1_addr (i_id_rs1_addr),
    .i_id_rs2_addr (i_id_rs2_addr),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_rd_addr  (i_ex_rd_addr),
    .i_ex_is_load  (i_ex_is_load),
    .o_hazard      (hazard)
  );

  // Mispredict wins over mret when both resolve in the same cycle
  assign redir_act = i_ex_mispredict || i_ex_mret;
  assign redir_pc  = i_ex_mispredict ? i_ex_target_pc : i_mepc;
  assign irq_take  = i_irq_pending && i_mie;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    o_pc_en       = 1'b1;
    o_if_id_en    = 1'b1;
    o_id_ex_en    = 1'b1;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = 32'h0;
    o_trap_take   = 1'b0;
    o_trap_epc    = epc_q;
    o_trap_cause  = cause_q;
    o_busy        = (state_q != ST_RUN);

    unique case (state_q)
      ST_RUN: begin
        if (irq_take) begin
          // The pending redirect becomes the resume point instead of being taken now
          state_d       = ST_DRAIN;
          cnt_d         = CNT_INIT;
          cause_d       = i_irq_cause;
          epc_d         = redir_act ? redir_pc : (i_id_insn_vld ? i_id_pc : i_if_pc);
          o_pc_en       = 1'b0;
          o_if_id_en    = 1'b0;
          o_id_ex_flush = 1'b1;
        end else if (redir_act) begin
          o_redirect    = 1'b1;
          o_redirect_pc = redir_pc;
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
        end else if (hazard) begin
          o_pc_en       = 1'b0;
          o_if_id_en    = 1'b0;
          o_id_ex_flush = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Trap is committed here: irq/mie changes are deliberately not sampled
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_flush = 1'b1;
        if (cnt_q == 2'd0) state_d = ST_TRAP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_TRAP: begin
        o_trap_take   = 1'b1;
        o_redirect    = 1'b1;
        o_redirect_pc = i_mtvec;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
        state_d       = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (!i_rst_n) begin
      state_d       = ST_RUN;
      cnt_d         = 2'd0;
      epc_d         = 32'h0;
      cause_d       = 4'h0;
      o_pc_en       = 1'b1;
      o_if_id_en    = 1'b1;
      o_id_ex_en    = 1'b1;
      o_if_id_flush = 1'b0;
      o_id_ex_flush = 1'b0;
      o_redirect    = 1'b0;
      o_redirect_pc = 32'h0;
      o_trap_take   = 1'b0;
      o_busy        = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    epc_q   <= epc_d;
    cause_q <= cause_d;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, redirects, interrupt drain/trap and reset abandon.
module tb_pipe_hazard_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [4:0]  i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
  logic        i_id_use_rs1, i_id_use_rs2, i_ex_is_load;
  logic        i_ex_mispredict, i_ex_mret;
  logic [31:0] i_ex_target_pc, i_mepc, i_mtvec, i_id_pc, i_if_pc;
  logic        i_irq_pending, i_mie, i_id_insn_vld;
  logic [3:0]  i_irq_cause;
  logic        o_pc_en, o_if_id_en, o_id_ex_en, o_if_id_flush, o_id_ex_flush;
  logic        o_redirect, o_trap_take, o_busy;
  logic [31:0] o_redirect_pc, o_trap_epc;
  logic [3:0]  o_trap_cause;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pipe_hazard_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_is_load(i_ex_is_load),
    .i_ex_mispredict(i_ex_mispredict), .i_ex_target_pc(i_ex_target_pc),
    .i_ex_mret(i_ex_mret), .i_mepc(i_mepc),
    .i_irq_pending(i_irq_pending), .i_irq_cause(i_irq_cause),
    .i_mie(i_mie), .i_mtvec(i_mtvec),
    .i_id_insn_vld(i_id_insn_vld), .i_id_pc(i_id_pc), .i_if_pc(i_if_pc),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_trap_take(o_trap_take), .o_trap_epc(o_trap_epc),
    .o_trap_cause(o_trap_cause), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packs {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, redirect, trap_take, busy}
  function automatic logic [31:0] ctl();
    return {24'h0, o_pc_en, o_if_id_en, o_id_ex_en, o_if_id_flush,
            o_id_ex_flush, o_redirect, o_trap_take, o_busy};
  endfunction

  task automatic idle();
    i_id_rs1_addr = 5'd0; i_id_rs2_addr = 5'd0; i_ex_rd_addr = 5'd0;
    i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0; i_ex_is_load = 1'b0;
    i_ex_mispredict = 1'b0; i_ex_mret = 1'b0;
    i_ex_target_pc = 32'h0; i_mepc = 32'h0; i_mtvec = 32'h200;
    i_id_pc = 32'h0; i_if_pc = 32'h0; i_id_insn_vld = 1'b0;
    i_irq_pending = 1'b0; i_irq_cause = 4'd0; i_mie = 1'b0;
  endtask

  // Each step: change inputs just after the falling edge, sample 1ns later
  task automatic step();
    @(negedge i_clk);
  endtask

  initial begin
    idle();
    i_rst_n = 1'b0;
    // Reset dominates active events
    step();
    i_ex_mispredict = 1'b1; i_ex_target_pc = 32'h100;
    i_irq_pending = 1'b1; i_mie = 1'b1; i_irq_cause = 4'd5;
    i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5; i_id_rs1_addr = 5'd5; i_id_use_rs1 = 1'b1;
    #1 chk("reset_ctl", ctl(), 32'b1110_0000);
    step(); idle();
    #1 chk("reset_ctl2", ctl(), 32'b1110_0000);

    i_rst_n = 1'b1;
    step(); idle();
    #1 chk("run_idle", ctl(), 32'b1110_0000);
    chk("run_epc_reset", o_trap_epc, 32'h0);
    chk("run_cause_reset", {28'h0, o_trap_cause}, 32'h0);

    // Load-use on rs1
    step(); idle();
    i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5; i_id_rs1_addr = 5'd5; i_id_use_rs1 = 1'b1;
    #1 chk("lu_rs1", ctl(), 32'b0010_1000);
    step();
    i_ex_rd_addr = 5'd0; i_id_rs1_addr = 5'd0;
    #1 chk("lu_x0", ctl(), 32'b1110_0000);
    step(); idle();
    i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd9; i_id_rs2_addr = 5'd9; i_id_use_rs2 = 1'b0;
    #1 chk("lu_rs2_unused", ctl(), 32'b1110_0000);
    i_id_use_rs2 = 1'b1;
    #1 chk("lu_rs2", ctl(), 32'b0010_1000);
    i_ex_is_load = 1'b0;
    #1 chk("lu_not_load", ctl(), 32'b1110_0000);

    // Mispredict with concurrent load-use
    step(); idle();
    i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5; i_id_rs1_addr = 5'd5; i_id_use_rs1 = 1'b1;
    i_ex_mispredict = 1'b1; i_ex_target_pc = 32'h100;
    #1 chk("mp_ctl", ctl(), 32'b1111_1100);
    chk("mp_pc", o_redirect_pc, 32'h100);

    step(); idle();
    i_ex_mret = 1'b1; i_mepc = 32'h80;
    #1 chk("mret_ctl", ctl(), 32'b1111_1100);
    chk("mret_pc", o_redirect_pc, 32'h80);
    i_ex_mispredict = 1'b1; i_ex_target_pc = 32'h104;
    #1 chk("mp_over_mret_pc", o_redirect_pc, 32'h104);

    // irq cause 11, ID valid at 0x40
    step(); idle();
    i_irq_pending = 1'b1; i_mie = 1'b1; i_irq_cause = 4'd11;
    i_id_insn_vld = 1'b1; i_id_pc = 32'h40; i_if_pc = 32'h44;
    #1 chk("irqA_entry", ctl(), 32'b0010_1000);
    step();
    #1 chk("irqA_drain1", ctl(), 32'b0010_1001);
    step();
    #1 chk("irqA_drain2", ctl(), 32'b0010_1001);
    step();
    // irq still pending in TRAP must not start a new drain
    #1 chk("irqA_trap", ctl(), 32'b1111_1111);
    chk("irqA_epc", o_trap_epc, 32'h40);
    chk("irqA_cause", {28'h0, o_trap_cause}, 32'd11);
    chk("irqA_mtvec", o_redirect_pc, 32'h200);

    // Re-evaluated in RUN: ID invalid -> resume at IF pc
    step();
    i_irq_cause = 4'd3; i_id_insn_vld = 1'b0;
    #1 chk("irqB_entry", ctl(), 32'b0010_1000);
    step();
    i_irq_pending = 1'b0; i_mie = 1'b0;
    #1 chk("irqB_drain1_dropped", ctl(), 32'b0010_1001);
    step();
    #1 chk("irqB_drain2", ctl(), 32'b0010_1001);
    step();
    #1 chk("irqB_trap", ctl(), 32'b1111_1111);
    chk("irqB_epc", o_trap_epc, 32'h44);
    chk("irqB_cause", {28'h0, o_trap_cause}, 32'd3);
    step();
    #1 chk("irqB_back_run", ctl(), 32'b1110_0000);

    // irq coincident with mret: redirect deferred into epc
    step(); idle();
    i_irq_pending = 1'b1; i_mie = 1'b1; i_irq_cause = 4'd7;
    i_ex_mret = 1'b1; i_mepc = 32'h80; i_id_insn_vld = 1'b1; i_id_pc = 32'h40;
    #1 chk("irqC_entry_no_redir", ctl(), 32'b0010_1000);
    step(); idle();
    #1 chk("irqC_drain1", ctl(), 32'b0010_1001);
    step();
    #1 chk("irqC_drain2", ctl(), 32'b0010_1001);
    step();
    #1 chk("irqC_trap", ctl(), 32'b1111_1111);
    chk("irqC_epc", o_trap_epc, 32'h80);
    chk("irqC_cause", {28'h0, o_trap_cause}, 32'd7);

    // Reset during DRAIN abandons the trap
    step(); idle();
    i_irq_pending = 1'b1; i_mie = 1'b1; i_irq_cause = 4'd9;
    #1 chk("irqD_entry", ctl(), 32'b0010_1000);
    step(); idle();
    #1 chk("irqD_drain1", ctl(), 32'b0010_1001);
    i_rst_n = 1'b0;
    #1 chk("irqD_rst_out", ctl(), 32'b1110_0000);
    step();
    i_rst_n = 1'b1;
    #1 chk("irqD_after_rst", ctl(), 32'b1110_0000);
    chk("irqD_epc_cleared", o_trap_epc, 32'h0);
    step();
    #1 chk("irqD_no_trap", ctl(), 32'b1110_0000);
    step();
    #1 chk("irqD_no_trap2", ctl(), 32'b1110_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
